// File: rtl/overture_io_host.sv
// Host-side I/O peripheral for the Overture CPU: input FIFO feeds in_port, output FIFO captures out_port.
// Define OVERTURE_IO_STALL_EN to stall the CPU on empty/full instead of flagging underflow/overflow.
module overture_io_host #(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run_in,
    output logic                         cpu_run,
    input  logic [7:0]                   cpu_instr,
    input  logic [7:0]                   cpu_out_port,
    output logic [7:0]                   cpu_in_port,
    input  logic                         in_wr_valid,
    input  logic [7:0]                   in_wr_data,
    output logic                         in_wr_ready,
    output logic                         out_rd_valid,
    output logic [7:0]                   out_rd_data,
    input  logic                         out_rd_ready,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         underflow,
    output logic                         overflow
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0]   IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [IAW:0]   IN_ONE   = (IAW+1)'(1);
    localparam logic [OAW:0]   OUT_ONE  = (OAW+1)'(1);
    localparam logic [OAW+1:0] OUT_LIM  = (OAW+2)'(OUT_DEPTH);

    logic [7:0]     in_mem  [IN_DEPTH];
    logic [7:0]     out_mem [OUT_DEPTH];
    logic [IAW-1:0] in_wp, in_rp;
    logic [OAW-1:0] out_wp, out_rp;
    logic           cap_pend;

    logic           copy, rd_req, wr_req, rd_evt, wr_evt;
    logic           in_empty, in_push, in_pop;
    logic           out_full_eff, wr_accept, out_pop;
    logic [OAW+1:0] out_occ;

    assign copy   = cpu_instr[7:6] == 2'b11;
    assign rd_req = copy & (cpu_instr[5:3] == 3'd6);
    assign wr_req = copy & (cpu_instr[2:0] == 3'd6);

    assign in_empty     = in_count == '0;
    assign in_wr_ready  = in_count != IN_FULL;
    assign cpu_in_port  = in_empty ? 8'h00 : in_mem[in_rp];

    // A capture still in flight already owns a slot in the output FIFO.
    assign out_occ      = {1'b0, out_count} + (OAW+2)'(cap_pend);
    assign out_full_eff = out_occ >= OUT_LIM;
    assign out_rd_valid = out_count != '0;
    assign out_rd_data  = out_rd_valid ? out_mem[out_rp] : 8'h00;

`ifdef OVERTURE_IO_STALL_EN
    assign cpu_run = run_in & ~(rd_req & in_empty) & ~(wr_req & out_full_eff);
`else
    assign cpu_run = run_in;
`endif

    assign rd_evt    = rd_req & cpu_run;
    assign wr_evt    = wr_req & cpu_run;
    assign in_push   = in_wr_valid & in_wr_ready;
    assign in_pop    = rd_evt & ~in_empty;
    assign wr_accept = wr_evt & ~out_full_eff;
    assign out_pop   = out_rd_valid & out_rd_ready;

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wp] <= in_wr_data;
        if (cap_pend)
            out_mem[out_wp] <= cpu_out_port;
    end

    // out_port only holds the written value after the executing edge, so capture lags by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wp     <= '0;
            in_rp     <= '0;
            in_count  <= '0;
            out_wp    <= '0;
            out_rp    <= '0;
            out_count <= '0;
            cap_pend  <= 1'b0;
        end else begin
            if (in_push)
                in_wp <= in_wp + 1'b1;
            if (in_pop)
                in_rp <= in_rp + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + IN_ONE;
                2'b01:   in_count <= in_count - IN_ONE;
                default: in_count <= in_count;
            endcase

            cap_pend <= wr_accept;
            if (cap_pend)
                out_wp <= out_wp + 1'b1;
            if (out_pop)
                out_rp <= out_rp + 1'b1;
            case ({cap_pend, out_pop})
                2'b10:   out_count <= out_count + OUT_ONE;
                2'b01:   out_count <= out_count - OUT_ONE;
                default: out_count <= out_count;
            endcase
        end
    end

`ifdef OVERTURE_IO_STALL_EN
    assign underflow = 1'b0;
    assign overflow  = 1'b0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (rd_evt & in_empty)
                underflow <= 1'b1;
            if (wr_evt & out_full_eff)
                overflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_overture_io_host.sv
// Directed self-checking bench for overture_io_host (both OVERTURE_IO_STALL_EN builds).
module tb_overture_io_host;
    logic       clk = 1'b0;
    logic       reset;
    logic       run_in;
    logic       cpu_run;
    logic [7:0] cpu_instr;
    logic [7:0] cpu_out_port;
    logic [7:0] cpu_in_port;
    logic       in_wr_valid;
    logic [7:0] in_wr_data;
    logic       in_wr_ready;
    logic       out_rd_valid;
    logic [7:0] out_rd_data;
    logic       out_rd_ready;
    logic [3:0] in_count;
    logic [3:0] out_count;
    logic       underflow;
    logic       overflow;

    int vec_count  = 0;
    int miss_count = 0;

    overture_io_host #(.IN_DEPTH(8), .OUT_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .run_in(run_in), .cpu_run(cpu_run),
        .cpu_instr(cpu_instr), .cpu_out_port(cpu_out_port), .cpu_in_port(cpu_in_port),
        .in_wr_valid(in_wr_valid), .in_wr_data(in_wr_data), .in_wr_ready(in_wr_ready),
        .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data), .out_rd_ready(out_rd_ready),
        .in_count(in_count), .out_count(out_count),
        .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] instr, input logic run, input logic [7:0] outp);
        cpu_instr    = instr;
        run_in       = run;
        cpu_out_port = outp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_wr_valid = 1'b0;
        in_wr_data = 8'h00;
        out_rd_ready = 1'b0;
        applyStimulus(8'h00, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("rst_in_count", in_count, 0);
        checkOutput("rst_out_count", out_count, 0);
        checkOutput("rst_in_ready", in_wr_ready, 1);
        checkOutput("rst_out_valid", out_rd_valid, 0);
        checkOutput("rst_in_port", cpu_in_port, 0);
        checkOutput("rst_out_data", out_rd_data, 0);
        checkOutput("rst_flags", {underflow, overflow}, 0);
        reset = 1'b1;
        tick();

        // Input stream: three pushes, then three consecutive CPU reads.
        for (int i = 0; i < 3; i++) begin
            in_wr_valid = 1'b1;
            in_wr_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        in_wr_valid = 1'b0;
        checkOutput("push_count", in_count, 3);
        applyStimulus(8'hF0, 1'b1, 8'h00);
        #1;
        checkOutput("rd0_data", cpu_in_port, 8'h11);
        checkOutput("rd0_run", cpu_run, 1);
        tick();
        checkOutput("rd1_data", cpu_in_port, 8'h22);
        checkOutput("rd1_count", in_count, 2);
        tick();
        checkOutput("rd2_data", cpu_in_port, 8'h33);
        checkOutput("rd2_count", in_count, 1);
        tick();
        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOutput("rd_done_count", in_count, 0);
        checkOutput("rd_done_port", cpu_in_port, 0);
        checkOutput("rd_no_underflow", underflow, 0);

        // Back-to-back output writes with the delayed out_port update.
        applyStimulus(8'hC6, 1'b1, 8'h00);
        tick();
        applyStimulus(8'hCE, 1'b1, 8'h5A);
        tick();
        checkOutput("wr_mid_count", out_count, 1);
        applyStimulus(8'h00, 1'b0, 8'hA5);
        tick();
        checkOutput("wr_count", out_count, 2);
        checkOutput("wr_valid", out_rd_valid, 1);
        checkOutput("wr_head0", out_rd_data, 8'h5A);
        out_rd_ready = 1'b1;
        tick();
        checkOutput("wr_head1", out_rd_data, 8'hA5);
        checkOutput("wr_pop_count", out_count, 1);
        tick();
        out_rd_ready = 1'b0;
        checkOutput("wr_empty_count", out_count, 0);
        checkOutput("wr_empty_valid", out_rd_valid, 0);
        checkOutput("wr_empty_data", out_rd_data, 0);

`ifdef OVERTURE_IO_STALL_EN
        // Stall on empty input FIFO until the host supplies a byte.
        applyStimulus(8'hF0, 1'b1, 8'h00);
        #1;
        checkOutput("stall_rd_run", cpu_run, 0);
        tick();
        checkOutput("stall_rd_run2", cpu_run, 0);
        in_wr_valid = 1'b1;
        in_wr_data  = 8'h7E;
        tick();
        in_wr_valid = 1'b0;
        checkOutput("stall_rd_release", cpu_run, 1);
        checkOutput("stall_rd_data", cpu_in_port, 8'h7E);
        tick();
        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOutput("stall_rd_count", in_count, 0);
        checkOutput("stall_no_underflow", underflow, 0);

        // Nine writes into eight slots: the ninth waits for a host pop.
        applyStimulus(8'hC6, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick();
            cpu_out_port = 8'(8'h80 + i);
        end
        checkOutput("stall_wr_run", cpu_run, 0);
        checkOutput("stall_wr_full", out_count, 8);
        out_rd_ready = 1'b1;
        tick();
        out_rd_ready = 1'b0;
        checkOutput("stall_wr_release", cpu_run, 1);
        tick();
        cpu_out_port = 8'h88;
        run_in = 1'b0;
        tick();
        checkOutput("stall_wr_count", out_count, 8);
        checkOutput("stall_no_overflow", overflow, 0);
        out_rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("stall_drain", out_rd_data, 8'(8'h81 + i));
            tick();
        end
        out_rd_ready = 1'b0;
        checkOutput("stall_drain_count", out_count, 0);
`else
        // Read on empty FIFO: CPU sees 0 and underflow latches.
        applyStimulus(8'hF0, 1'b1, 8'h00);
        #1;
        checkOutput("uf_run", cpu_run, 1);
        checkOutput("uf_data", cpu_in_port, 0);
        tick();
        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOutput("uf_flag", underflow, 1);
        checkOutput("uf_count", in_count, 0);

        // Nine writes into eight slots: the ninth is dropped, overflow latches.
        applyStimulus(8'hC6, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick();
            cpu_out_port = 8'(8'h80 + i);
        end
        run_in = 1'b0;
        checkOutput("of_flag", overflow, 1);
        checkOutput("of_count", out_count, 8);
        tick();
        checkOutput("of_no_extra", out_count, 8);
        checkOutput("uf_sticky", underflow, 1);
        out_rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("of_drain", out_rd_data, 8'(8'h80 + i));
            tick();
        end
        out_rd_ready = 1'b0;
        checkOutput("of_drain_count", out_count, 0);
        checkOutput("of_sticky", overflow, 1);
`endif

        // Reset while a capture is pending and input entries are queued.
        for (int i = 0; i < 3; i++) begin
            in_wr_valid = 1'b1;
            in_wr_data  = 8'(8'h40 + i);
            tick();
        end
        in_wr_valid = 1'b0;
        checkOutput("mid_in_count", in_count, 3);
        applyStimulus(8'hC6, 1'b1, 8'h00);
        tick();
        applyStimulus(8'h00, 1'b0, 8'h99);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_in", in_count, 0);
        checkOutput("mid_rst_out", out_count, 0);
        checkOutput("mid_rst_flags", {underflow, overflow}, 0);
        checkOutput("mid_rst_ready", in_wr_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        checkOutput("mid_post_count", out_count, 0);
        checkOutput("mid_post_valid", out_rd_valid, 0);
        checkOutput("mid_post_port", cpu_in_port, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/overture_io_host.md
Name: overture_io_host

Overview:
- Host-side peripheral at the far end of the Overture CPU's in_port/out_port interface.
- Snoops the CPU instruction byte to detect input reads and output writes.
- Feeds in_port from an input FIFO loaded by the host, and captures out_port writes into an output FIFO drained by the host.
- Used by program wrappers and benches to stream data to and from Overture programs without hand-driving pins.

Parameters:
- IN_DEPTH, 8, input FIFO entries (power of two, ≥2)
- OUT_DEPTH, 8, output FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- run_in  input  1  run request from the host
- cpu_run  output  1  gated run, driven to the CPU run input
- cpu_instr  input  8  CPU instr_debug
- cpu_out_port  input  8  CPU out_port
- cpu_in_port  output  8  driven to the CPU in_port
- in_wr_valid  input  1  host push request, input FIFO
- in_wr_data  input  8  host push data
- in_wr_ready  output  1  input FIFO not full
- out_rd_valid  output  1  output FIFO not empty
- out_rd_data  output  8  output FIFO head
- out_rd_ready  input  1  host pop request
- in_count  output  $clog2(IN_DEPTH)+1  input FIFO occupancy
- out_count  output  $clog2(OUT_DEPTH)+1  output FIFO occupancy
- underflow  output  1  sticky: read from empty input FIFO
- overflow  output  1  sticky: write dropped on full output FIFO

Behaviour:
- Reset (async, reset=0): both FIFOs empty, pointers and counts 0, cap_pend=0, underflow=0, overflow=0. Outputs: cpu_in_port=0, out_rd_data=0, out_rd_valid=0, in_wr_ready=1.
- Decode: copy = cpu_instr[7:6]==2'b11; src = cpu_instr[5:3]; dst = cpu_instr[2:0].
  - rd_evt = copy & src==6 & cpu_run
  - wr_evt = copy & dst==6 & cpu_run
  - Both may be set at once (copy input->output).
- cpu_in_port: combinational input FIFO head when not empty, else 0.
- Input FIFO:
  - Push when in_wr_valid & in_wr_ready.
  - Pop on the rising edge where rd_evt & !empty.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Push while full is ignored (ready=0).
- Output capture:
  - The CPU updates out_port on the edge that executes the write, so capture is delayed by one cycle.
  - On the edge where wr_evt is accepted, set cap_pend.
  - On the next edge, write cpu_out_port into the output FIFO and clear cap_pend.
  - Back-to-back writes: cap_pend is set and cleared on the same edge; every write is captured.
- out_full_eff = (out_count + cap_pend) ≥ OUT_DEPTH. A host pop in the same cycle does not relieve out_full_eff.
- out_rd_data = output FIFO head (0 when empty). Pop when out_rd_valid & out_rd_ready. A simultaneous capture and pop leaves the count unchanged.
- cpu_run, stall build (see Optional Feature): run_in & ~(copy & src==6 & in_empty) & ~(copy & dst==6 & out_full_eff).
  - A stalled instruction holds the PC, so cpu_instr stays stable.
  - The instruction retries each cycle and produces no event while stalled.
- Counts: in_count/out_count are registered and exact, range 0..DEPTH. Pointers wrap modulo DEPTH.
- Reset asserted mid-capture: the pending capture is discarded.

Optional Feature:
- Macro: OVERTURE_IO_STALL_EN.
- Defined: stall behaviour as above. underflow/overflow never set.
- Undefined: cpu_run = run_in, never stalled.
  - Read on empty input FIFO: CPU sees 0, no pop, underflow set.
  - Write when out_full_eff: value not captured (cap_pend not set), overflow set.
  - Sticky flags clear only on reset.

Test Plan:
- Push 0x11,0x22,0x33; run input-read instructions (0xF0, src6->r0) with run_in=1 -> cpu_in_port shows 0x11, 0x22, 0x33 on successive reads; in_count 3->0.
- CPU executes 0xC6 (r0->out) with out_port=0x5A, then 0xCE (r1->out) with 0xA5 on consecutive cycles -> output FIFO holds 0x5A then 0xA5; out_count=2; host pops in order.
- STALL_EN defined: input FIFO empty, instr 0xF0, run_in=1 -> cpu_run=0 while empty; host pushes 0x7E -> cpu_run=1 the same cycle, read completes, in_count back to 0.
- STALL_EN defined: fill output FIFO to OUT_DEPTH=8 via writes, then a 9th write -> cpu_run=0 until host pops one; the 9th value is captured, out_count ends at 8.
- STALL_EN undefined: read with empty FIFO -> cpu_in_port=0, underflow=1. 9 writes to an 8-entry FIFO -> 8 captured, overflow=1.
- Assert reset=0 one cycle after a write (cap_pend=1) with 3 input entries queued -> all counts 0, flags 0, no capture after release.
